// File: rtl/dm_write_tracer.sv
// Trace buffer for data-memory writes: captures {addr, data, stamp} per DM write and
// streams the captured entries out oldest-first over valid/ready when a dump is requested.
module dm_write_tracer #(
    parameter int unsigned N            = 64,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned TS_W         = 16,
    parameter bit          STOP_ON_FULL = 1'b0
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     DM_writeEnable,
    input  logic [N-1:0]             DM_addr,
    input  logic [N-1:0]             DM_writeData,
    input  logic                     dump,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_addr,
    output logic [N-1:0]             out_data,
    output logic [TS_W-1:0]          out_stamp,
    output logic                     out_last,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {StCapture, StDump, StDone} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TS_W-1:0] stamp_q;
    logic            dump_q;
    logic            overflow_q, overflow_d;
    logic            mem_we;
    logic            full;
    logic            dump_rise;

    logic [N-1:0]    mem_addr  [DEPTH];
    logic [N-1:0]    mem_data  [DEPTH];
    logic [TS_W-1:0] mem_stamp [DEPTH];

    assign full      = (count_q == CW'(DEPTH));
    assign dump_rise = dump & ~dump_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        unique case (state_q)
            StCapture: begin
                if (DM_writeEnable) begin
                    if (!full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                    end else if (!STOP_ON_FULL) begin
                        // Overwrite the oldest entry; the read side slides forward with it.
                        mem_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + 1'b1;
                        rd_ptr_d   = rd_ptr_q + 1'b1;
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                if (dump_rise) begin
                    state_d = (count_d != '0) ? StDump : StDone;
                end
            end
            StDump: begin
                out_valid = 1'b1;
                out_last  = (count_q == CW'(1));
                if (DM_writeEnable) begin
                    overflow_d = 1'b1;
                end
                if (out_ready) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                    if (count_q == CW'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (DM_writeEnable) begin
                    overflow_d = 1'b1;
                end
                if (!dump) begin
                    state_d    = StCapture;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end
            end
            default: state_d = StCapture;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= StCapture;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            stamp_q    <= '0;
            dump_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            stamp_q    <= stamp_q + 1'b1;
            dump_q     <= dump;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset && mem_we) begin
            mem_addr[wr_ptr_q]  <= DM_addr;
            mem_data[wr_ptr_q]  <= DM_writeData;
            mem_stamp[wr_ptr_q] <= stamp_q;
        end
    end

    assign out_addr  = out_valid ? mem_addr[rd_ptr_q]  : '0;
    assign out_data  = out_valid ? mem_data[rd_ptr_q]  : '0;
    assign out_stamp = out_valid ? mem_stamp[rd_ptr_q] : '0;
    assign busy      = (state_q != StCapture);
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_dm_write_tracer.sv
// Scoreboard bench for dm_write_tracer: three instances (depth 16 overwrite, depth 4
// overwrite, depth 4 stop-on-full) exercised one at a time; a monitor checks every beat.
module tb_dm_write_tracer;

    typedef struct {
        int          d;
        logic [63:0] a;
        logic [63:0] w;
        logic [15:0] s;
        logic        l;
    } beat_t;

    logic        clk;
    logic        rst   [3];
    logic        we    [3];
    logic [63:0] addr  [3];
    logic [63:0] wdata [3];
    logic        dump  [3];
    logic        ready [3];
    logic        ov    [3];
    logic        ol    [3];
    logic        bsy   [3];
    logic        ovf   [3];
    logic [63:0] oa    [3];
    logic [63:0] od    [3];
    logic [15:0] os    [3];
    logic [4:0]  cnt0;
    logic [2:0]  cnt1;
    logic [2:0]  cnt2;

    beat_t exp_q[$];
    beat_t e;
    int    errors = 0;
    int    checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dm_write_tracer #(.N(64), .DEPTH(16), .TS_W(16), .STOP_ON_FULL(1'b0)) u_dut16 (
        .CLOCK_50(clk), .reset(rst[0]), .DM_writeEnable(we[0]), .DM_addr(addr[0]),
        .DM_writeData(wdata[0]), .dump(dump[0]), .out_valid(ov[0]), .out_ready(ready[0]),
        .out_addr(oa[0]), .out_data(od[0]), .out_stamp(os[0]), .out_last(ol[0]),
        .busy(bsy[0]), .count(cnt0), .overflow(ovf[0])
    );

    dm_write_tracer #(.N(64), .DEPTH(4), .TS_W(16), .STOP_ON_FULL(1'b0)) u_dut4o (
        .CLOCK_50(clk), .reset(rst[1]), .DM_writeEnable(we[1]), .DM_addr(addr[1]),
        .DM_writeData(wdata[1]), .dump(dump[1]), .out_valid(ov[1]), .out_ready(ready[1]),
        .out_addr(oa[1]), .out_data(od[1]), .out_stamp(os[1]), .out_last(ol[1]),
        .busy(bsy[1]), .count(cnt1), .overflow(ovf[1])
    );

    dm_write_tracer #(.N(64), .DEPTH(4), .TS_W(16), .STOP_ON_FULL(1'b1)) u_dut4s (
        .CLOCK_50(clk), .reset(rst[2]), .DM_writeEnable(we[2]), .DM_addr(addr[2]),
        .DM_writeData(wdata[2]), .dump(dump[2]), .out_valid(ov[2]), .out_ready(ready[2]),
        .out_addr(oa[2]), .out_data(od[2]), .out_stamp(os[2]), .out_last(ol[2]),
        .busy(bsy[2]), .count(cnt2), .overflow(ovf[2])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Beats are compared on every cycle out_valid is high; popped only on handshake.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ov[d]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(d), 64'hffff);
                end else begin
                    e = exp_q[0];
                    check("beat_dut", 64'(d), 64'(e.d));
                    check("beat_addr", oa[d], e.a);
                    check("beat_data", od[d], e.w);
                    check("beat_stamp", 64'(os[d]), 64'(e.s));
                    check("beat_last", 64'(ol[d]), 64'(e.l));
                    if (ready[d]) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d, input int cycles);
        rst[d] = 1'b1;
        repeat (cycles) step();
        rst[d] = 1'b0;
    endtask

    task automatic wr(input int d, input logic [63:0] a, input logic [63:0] w);
        we[d]    = 1'b1;
        addr[d]  = a;
        wdata[d] = w;
        step();
        we[d]    = 1'b0;
    endtask

    task automatic exp_beat(input int d, input logic [63:0] a, input logic [63:0] w,
                            input logic [15:0] s, input logic l);
        beat_t b;
        b.d = d; b.a = a; b.w = w; b.s = s; b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
            dump[d] = 1'b0; ready[d] = 1'b0;
        end
        step(); step();
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        // Basic dump: three writes with gaps, full-rate drain.
        do_reset(0, 2);
        check("rst_valid", 64'(ov[0]), 64'd0);
        check("rst_busy", 64'(bsy[0]), 64'd0);
        check("rst_count", 64'(cnt0), 64'd0);
        check("rst_overflow", 64'(ovf[0]), 64'd0);
        check("rst_last", 64'(ol[0]), 64'd0);
        step(); step();
        wr(0, 64'h10, 64'hAA);
        wr(0, 64'h18, 64'hBB);
        step(); step(); step();
        wr(0, 64'h20, 64'hCC);
        check("t1_count3", 64'(cnt0), 64'd3);
        exp_beat(0, 64'h10, 64'hAA, 16'd2, 1'b0);
        exp_beat(0, 64'h18, 64'hBB, 16'd3, 1'b0);
        exp_beat(0, 64'h20, 64'hCC, 16'd7, 1'b1);
        ready[0] = 1'b1;
        dump[0]  = 1'b1;
        step();
        drain();
        check("t1_count0", 64'(cnt0), 64'd0);
        check("t1_overflow", 64'(ovf[0]), 64'd0);
        check("t1_busy_done", 64'(bsy[0]), 64'd1);
        dump[0] = 1'b0;
        step();
        check("t1_busy_fall", 64'(bsy[0]), 64'd0);

        // Depth 4, overwrite oldest.
        do_reset(1, 1);
        for (int i = 1; i <= 6; i++) wr(1, 64'h100 + 64'(i), 64'(i));
        check("t2_count", 64'(cnt1), 64'd4);
        check("t2_overflow", 64'(ovf[1]), 64'd1);
        for (int i = 3; i <= 6; i++) exp_beat(1, 64'h100 + 64'(i), 64'(i), 16'(i - 1), i == 6);
        ready[1] = 1'b1;
        dump[1]  = 1'b1;
        step();
        drain();
        dump[1] = 1'b0;
        step();
        check("t2_busy", 64'(bsy[1]), 64'd0);
        check("t2_ovf_clr", 64'(ovf[1]), 64'd0);

        // Depth 4, discard when full.
        do_reset(2, 1);
        for (int i = 1; i <= 6; i++) wr(2, 64'h100 + 64'(i), 64'(i));
        check("t3_count", 64'(cnt2), 64'd4);
        check("t3_overflow", 64'(ovf[2]), 64'd1);
        for (int i = 1; i <= 4; i++) exp_beat(2, 64'h100 + 64'(i), 64'(i), 16'(i - 1), i == 4);
        ready[2] = 1'b1;
        dump[2]  = 1'b1;
        step();
        drain();
        dump[2] = 1'b0;
        step();

        // Backpressure, plus a write during the dump that must not appear.
        do_reset(0, 1);
        wr(0, 64'h40, 64'h11);
        wr(0, 64'h48, 64'h22);
        exp_beat(0, 64'h40, 64'h11, 16'd0, 1'b0);
        exp_beat(0, 64'h48, 64'h22, 16'd1, 1'b1);
        ready[0] = 1'b0;
        dump[0]  = 1'b1;
        step();
        wr(0, 64'h50, 64'h33);
        step(); step();
        check("t4_held", 64'(exp_q.size()), 64'd2);
        ready[0] = 1'b1;
        drain();
        check("t4_overflow", 64'(ovf[0]), 64'd1);
        dump[0] = 1'b0;
        step();

        // Empty dump, then a write coinciding with the dump rise.
        do_reset(0, 1);
        dump[0] = 1'b1;
        step();
        check("t5_busy", 64'(bsy[0]), 64'd1);
        check("t5_valid", 64'(ov[0]), 64'd0);
        step(); step();
        check("t5_busy_hold", 64'(bsy[0]), 64'd1);
        dump[0] = 1'b0;
        step();
        check("t5_busy_fall", 64'(bsy[0]), 64'd0);
        exp_beat(0, 64'h80, 64'h55, 16'd4, 1'b1);
        dump[0] = 1'b1;
        wr(0, 64'h80, 64'h55);
        drain();
        dump[0] = 1'b0;
        step();

        // Reset in the middle of a dump.
        do_reset(0, 1);
        for (int i = 0; i < 5; i++) begin
            wr(0, 64'h200 + 64'(i), 64'h1000 + 64'(i));
            exp_beat(0, 64'h200 + 64'(i), 64'h1000 + 64'(i), 16'(i), i == 4);
        end
        ready[0] = 1'b1;
        dump[0]  = 1'b1;
        step();
        step(); step();
        rst[0]   = 1'b1;
        ready[0] = 1'b0;
        dump[0]  = 1'b0;
        step();
        rst[0] = 1'b0;
        check("t6_left", 64'(exp_q.size()), 64'd3);
        exp_q.delete();
        check("t6_valid", 64'(ov[0]), 64'd0);
        check("t6_count", 64'(cnt0), 64'd0);
        check("t6_busy", 64'(bsy[0]), 64'd0);
        check("t6_overflow", 64'(ovf[0]), 64'd0);
        ready[0] = 1'b1;
        exp_beat(0, 64'h300, 64'h33, 16'd0, 1'b1);
        dump[0] = 1'b1;
        wr(0, 64'h300, 64'h33);
        drain();
        dump[0] = 1'b0;
        step();
        check("t6_busy_end", 64'(bsy[0]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_write_tracer.md
Name: dm_write_tracer

Overview:
Synthesizable trace buffer that captures data-memory write transactions (address, data, cycle stamp) from the single-cycle processor's DM write port. On a dump request it streams the captured entries out, oldest first, over a valid/ready interface. This generalises the processor's dump behaviour with parametrised width and depth, selectable overflow mode, backpressure and timestamps. It sits beside processor_arm and observes DM_writeEnable/DM_addr/DM_writeData.

Parameters:
N, 64, address/data width in bits
DEPTH, 16, number of trace entries; power of two, >=2
TS_W, 16, cycle-stamp width in bits
STOP_ON_FULL, 0, 0 = overwrite oldest entry when full; 1 = discard new writes when full

Ports:
CLOCK_50  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
DM_writeEnable  input  1  DM write strobe; one write captured per cycle it is high
DM_addr  input  N  DM write address
DM_writeData  input  N  DM write data
dump  input  1  level request; a rising edge (dump high, previous-cycle dump low) starts a dump
out_valid  output  1  current output entry is valid
out_ready  input  1  consumer accepts entry when out_valid && out_ready
out_addr  output  N  entry address
out_data  output  N  entry data
out_stamp  output  TS_W  cycle stamp of entry
out_last  output  1  high with out_valid on the final entry
busy  output  1  high in DUMP and DONE
count  output  $clog2(DEPTH)+1  entries currently held
overflow  output  1  sticky: a write was lost or overwritten

Behaviour:
- One clock, synchronous active-high reset. Reset: state CAPTURE, count=0, pointers=0, stamp counter=0, dump_q=0, overflow=0, out_valid=0, out_last=0, busy=0. Reset takes priority over all other events, including mid-dump; an in-progress dump is abandoned and the buffer emptied.
- Stamp counter: 0 in the first cycle after reset deasserts, +1 every cycle, wraps modulo 2^TS_W. It runs in all states.
- Storage: register array of DEPTH entries {addr, data, stamp}. wr_ptr and rd_ptr wrap modulo DEPTH.
- States: CAPTURE, DUMP, DONE.
- CAPTURE: if DM_writeEnable, store {DM_addr, DM_writeData, stamp} at wr_ptr.
  - Not full: count+1.
  - Full, STOP_ON_FULL=0: oldest entry overwritten, rd_ptr advances, count stays DEPTH, overflow<=1.
  - Full, STOP_ON_FULL=1: write discarded, overflow<=1.
  - If a dump rising edge is sampled at the same edge, the write in that cycle is still captured. The state becomes DUMP if count after that write is >0; otherwise the state becomes DONE.
- DUMP: no captures take place. Any DM_writeEnable sets overflow<=1.
  - out_valid=1. out_addr/out_data/out_stamp are read combinationally from mem[rd_ptr]. out_last=(count==1).
  - The first out_valid appears in the cycle immediately after the edge that sampled the dump rise.
  - Outputs hold stable while out_ready=0.
  - On handshake: rd_ptr+1, count-1. The handshake on the last entry moves the state to DONE.
- DONE: out_valid=0, out_last=0. DM writes are not captured and set overflow. When dump is sampled low, go to CAPTURE; the buffer stays empty (count=0) and overflow is cleared.
- busy=1 exactly in DUMP and DONE.
- dump held high through DONE does not retrigger; a new rising edge is required after returning to CAPTURE.
- Outputs not covered above are 0 when out_valid=0.

Test Plan:
- DEPTH=16: reset for 2 cycles, then DM writes (0x10,0xAA) at stamp 2, (0x18,0xBB) at stamp 3, (0x20,0xCC) at stamp 7; dump rise with out_ready=1 -> three beats in order with stamps 2,3,7; out_last only on the 0x20 beat; count 3->0; overflow=0; busy falls after dump drops.
- DEPTH=4, STOP_ON_FULL=0: 6 consecutive writes with data 1..6, then dump -> beats data 3,4,5,6; overflow=1; count=4 before dump.
- DEPTH=4, STOP_ON_FULL=1: same stimulus -> beats data 1,2,3,4; overflow=1.
- Backpressure: 2 entries; out_ready low for 3 cycles, then high -> first entry held stable for 4 cycles, then the second entry; a DM write during DUMP is not output and sets overflow=1.
- Empty dump: dump rise with no writes -> out_valid never asserts; busy=1 until dump falls; a write in the same cycle as the dump rise yields exactly one beat with out_last=1.
- Reset mid-dump: 5 entries, reset asserted after 2 beats -> next cycle out_valid=0, count=0, busy=0, stamp=0, overflow=0.
